// File: rtl/cp0_if.sv
// Controller <-> coprocessor-0 bus: MTC0/MFC0 access, interrupt inputs and the
// PC redirect back to the fetch/ID stages.
interface cp0_if;
   logic [1:0]  cp_oper;
   logic [4:0]  addr_w;
   logic [31:0] data_w;
   logic [4:0]  addr_r;
   logic [31:0] data_r;
   logic        ir_en;
   logic        ir_in;
   logic [31:0] ret_addr;
   logic        id_valid;
   logic        stall;
   logic        jump_en;
   logic [31:0] jump_addr;

   modport master (
      output cp_oper, addr_w, data_w, addr_r, ir_en, ir_in, ret_addr, id_valid, stall,
      input  data_r, jump_en, jump_addr
   );
   modport slave (
      input  cp_oper, addr_w, data_w, addr_r, ir_en, ir_in, ret_addr, id_valid, stall,
      output data_r, jump_en, jump_addr
   );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: STATUS/CAUSE/EPC/COUNT/COMPARE/EBASE, external + timer
// interrupts, MTC0/MFC0/ERET, and the PC redirect for interrupt entry/return.
module cp0_unit #(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_0040,
   parameter int          SYNC_STAGES  = 2
) (
   input logic   clk,
   input logic   rst,
   cp0_if.slave  bus
);
   localparam logic [1:0] OP_STORE = 2'd1;
   localparam logic [1:0] OP_ERET  = 2'd2;

   // EXL is the state bit itself
   typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} state_t;
   state_t state;

   logic [SYNC_STAGES-1:0] ir_sync;
   logic                   ir_prev;
   logic [31:0]            count, compare, epc, ebase;
   logic                   ie, ip2, ip7;
   logic [7:0]             im;
   logic [4:0]             exc_code;

   logic        exl, commit, take, eret, mtc0, ir_rise;
   logic [7:0]  ip;
   logic [31:0] status_q, cause_q;

   assign exl      = (state == HANDLER);
   assign ip       = {ip7, 4'b0, ip2, 2'b0};
   assign status_q = {16'b0, im, 6'b0, exl, ie};
   assign cause_q  = {16'b0, ip7, 4'b0, ip2, 3'b0, exc_code, 2'b0};
   assign ir_rise  = ir_sync[SYNC_STAGES-1] & ~ir_prev;

   assign commit = bus.id_valid & ~bus.stall & ~rst;
   assign eret   = commit & (bus.cp_oper == OP_ERET);
   assign take   = commit & bus.ir_en & ie & ~exl & (|(ip & im)) & (bus.cp_oper != OP_ERET);
   // a taken interrupt flushes ID, so its MTC0 never lands
   assign mtc0   = commit & (bus.cp_oper == OP_STORE) & ~take;

   assign bus.jump_en   = take | eret;
   assign bus.jump_addr = take ? ebase : (eret ? epc : 32'h0);

   always_comb begin
      bus.data_r = 32'h0;
      case (bus.addr_r)
         5'd9:    bus.data_r = count;
         5'd11:   bus.data_r = compare;
         5'd12:   bus.data_r = status_q;
         5'd13:   bus.data_r = cause_q;
         5'd14:   bus.data_r = epc;
         5'd15:   bus.data_r = ebase;
         default: bus.data_r = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= NORMAL;
         ir_sync  <= '0;
         ir_prev  <= 1'b0;
         count    <= 32'h0;
         compare  <= 32'hFFFF_FFFF;
         epc      <= 32'h0;
         ebase    <= HANDLER_ADDR;
         ie       <= 1'b0;
         im       <= 8'h0;
         ip2      <= 1'b0;
         ip7      <= 1'b0;
         exc_code <= 5'h0;
      end else begin
         ir_sync <= {ir_sync[SYNC_STAGES-2:0], bus.ir_in};
         ir_prev <= ir_sync[SYNC_STAGES-1];

         count <= (mtc0 && bus.addr_w == 5'd9) ? bus.data_w : count + 32'd1;

         // a COMPARE write acknowledges the timer even on a same-cycle match
         if (mtc0 && bus.addr_w == 5'd11) begin
            compare <= bus.data_w;
            ip7     <= 1'b0;
         end else if (count == compare) begin
            ip7 <= 1'b1;
         end

         if (ir_rise)
            ip2 <= 1'b1;
         else if (mtc0 && bus.addr_w == 5'd13)
            ip2 <= bus.data_w[10];

         if (mtc0 && bus.addr_w == 5'd12) begin
            ie <= bus.data_w[0];
            im <= bus.data_w[15:8];
         end
         if (mtc0 && bus.addr_w == 5'd15)
            ebase <= bus.data_w;

         if (take) begin
            epc      <= bus.ret_addr;
            exc_code <= 5'h0;
         end else if (mtc0 && bus.addr_w == 5'd14) begin
            epc <= bus.data_w;
         end

         case (state)
            NORMAL:  if (take || (mtc0 && bus.addr_w == 5'd12 && bus.data_w[1]))
                        state <= HANDLER;
            HANDLER: if (eret || (mtc0 && bus.addr_w == 5'd12 && !bus.data_w[1]))
                        state <= NORMAL;
            default: state <= NORMAL;
         endcase
      end
   end
endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: the driver pushes model-predicted outputs per
// cycle, a negedge monitor pops and compares them against the DUT.
module tb_cp0_unit;
   localparam int S = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cp0_if bus ();
   cp0_unit #(.HANDLER_ADDR(32'h0000_0040), .SYNC_STAGES(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  op;
      logic [4:0]  aw;
      logic [31:0] dw;
      logic [4:0]  ar;
      logic        ien, ir;
      logic [31:0] ret;
      logic        vld, stl;
   } stim_t;

   typedef struct {
      logic        jen;
      logic [31:0] jaddr;
      logic [31:0] dr;
   } exp_t;

   exp_t  sbq[$];
   int    total = 0;
   int    bad   = 0;

   // architectural model: whole register words
   bit [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_ebase;
   bit        m_hist[$];
   bit        mvalid = 1'b0;
   stim_t     cur;

   function automatic bit [31:0] rd(input bit [4:0] a);
      case (a)
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return m_ebase;
         default: return 32'h0;
      endcase
   endfunction

   function automatic void decide(input stim_t s, output bit tk, output bit er);
      bit commit, pend;
      commit = s.vld && !s.stl && !s.rst;
      pend   = (m_cause[15:8] & m_status[15:8]) != 8'h0;
      tk     = commit && s.ien && m_status[0] && !m_status[1] && pend && s.op != 2'd2;
      er     = commit && s.op == 2'd2;
   endfunction

   task automatic model_edge(input stim_t s);
      bit tk, er, wr, rise, match;
      bit [31:0] dw;
      if (s.rst) begin
         m_count = 0; m_compare = 32'hFFFF_FFFF; m_status = 0; m_cause = 0;
         m_epc = 0; m_ebase = 32'h40;
         m_hist.delete();
         for (int i = 0; i <= S; i++) m_hist.push_back(1'b0);
         mvalid = 1'b1;
         return;
      end
      if (!mvalid) return;
      decide(s, tk, er);
      wr    = s.vld && !s.stl && s.op == 2'd1 && !tk;
      dw    = s.dw;
      rise  = m_hist[1] && !m_hist[0];
      match = (m_count == m_compare);
      m_hist.push_back(s.ir);
      void'(m_hist.pop_front());

      m_count = m_count + 1;
      if (match) m_cause[15] = 1'b1;
      if (wr) begin
         case (s.aw)
            5'd9:  m_count = dw;
            5'd11: begin m_compare = dw; m_cause[15] = 1'b0; end
            5'd12: m_status = dw & 32'h0000_FF03;
            5'd13: m_cause[10] = dw[10];
            5'd14: m_epc = dw;
            5'd15: m_ebase = dw;
            default: ;
         endcase
      end
      if (rise) m_cause[10] = 1'b1;
      if (tk) begin
         m_epc = s.ret;
         m_status[1] = 1'b1;
         m_cause[6:2] = 5'h0;
      end
      if (er) m_status[1] = 1'b0;
   endtask

   task automatic step(input stim_t s);
      bit tk, er;
      exp_t e;
      @(posedge clk);
      model_edge(cur);
      #1;
      cur = s;
      rst = s.rst;
      bus.cp_oper = s.op;  bus.addr_w = s.aw;   bus.data_w = s.dw;
      bus.addr_r = s.ar;   bus.ir_en = s.ien;   bus.ir_in = s.ir;
      bus.ret_addr = s.ret; bus.id_valid = s.vld; bus.stall = s.stl;
      if (mvalid) begin
         decide(s, tk, er);
         e.jen   = tk || er;
         e.jaddr = tk ? m_ebase : (er ? m_epc : 32'h0);
         e.dr    = rd(s.ar);
         sbq.push_back(e);
      end
   endtask

   task automatic cyc(input logic [1:0] op, input logic [4:0] aw, input logic [31:0] dw,
                      input logic [4:0] ar, input logic ir, input logic stl,
                      input logic [31:0] ret);
      stim_t s;
      s.rst = 0; s.op = op; s.aw = aw; s.dw = dw; s.ar = ar; s.ien = 1;
      s.ir = ir; s.ret = ret; s.vld = 1; s.stl = stl;
      step(s);
   endtask

   task automatic do_reset(input int n);
      stim_t s;
      s = '{rst: 1, op: 0, aw: 0, dw: 0, ar: 5'd15, ien: 0, ir: 0, ret: 0, vld: 0, stl: 0};
      for (int i = 0; i < n; i++) step(s);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @%0t got=%h exp=%h", nm, $time, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("jump_en",   {31'b0, bus.jump_en}, {31'b0, e.jen});
         chk("jump_addr", bus.jump_addr, e.jaddr);
         chk("data_r",    bus.data_r, e.dr);
      end
   end

   initial begin
      stim_t s;
      logic  ir_lvl;
      cur = '{rst: 1, op: 0, aw: 0, dw: 0, ar: 0, ien: 0, ir: 0, ret: 0, vld: 0, stl: 0};
      rst = 1'b1;
      bus.cp_oper = 0; bus.addr_w = 0; bus.data_w = 0; bus.addr_r = 0; bus.ir_en = 0;
      bus.ir_in = 0; bus.ret_addr = 0; bus.id_valid = 0; bus.stall = 0;

      // external interrupt take, then clear IP2 and return
      do_reset(3);
      cyc(1, 12, 32'h0000_0401, 12, 0, 0, 32'h100);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 13, 1, 0, 32'h120);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 14, 0, 0, 32'h120);
      cyc(0, 0, 0, 12, 0, 0, 32'h300);
      cyc(1, 13, 32'h0, 13, 0, 0, 32'h304);
      cyc(2, 0, 0, 13, 0, 0, 32'h308);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 12, 0, 0, 32'h120);

      // pending interrupt held off by stall
      do_reset(2);
      cyc(1, 12, 32'h0000_0401, 12, 0, 0, 32'h100);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 13, 1, 1, 32'h120);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 13, 0, 1, 32'h124);
      cyc(0, 0, 0, 14, 0, 0, 32'h200);
      cyc(0, 0, 0, 14, 0, 0, 32'h204);

      // timer interrupt, then acknowledge via COMPARE
      do_reset(2);
      cyc(1, 11, 32'd10, 11, 0, 0, 32'h10);
      cyc(1, 9, 32'd5, 9, 0, 0, 32'h14);
      cyc(1, 12, 32'h0000_8001, 9, 0, 0, 32'h18);
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 13, 0, 0, 32'h1C);
      cyc(1, 11, 32'd100, 13, 0, 0, 32'h40);
      cyc(0, 0, 0, 13, 0, 0, 32'h44);

      // ERET coincident with a pending enabled interrupt
      do_reset(2);
      cyc(1, 12, 32'h0000_0403, 12, 0, 0, 32'h0);
      cyc(1, 14, 32'h0000_0500, 14, 0, 0, 32'h0);
      cyc(1, 13, 32'h0000_0400, 13, 0, 0, 32'h0);
      cyc(2, 0, 0, 12, 0, 0, 32'h80);
      cyc(0, 0, 0, 14, 0, 0, 32'h600);
      cyc(0, 0, 0, 14, 0, 0, 32'h604);

      // COUNT wrap and unmapped read
      cyc(1, 9, 32'hFFFF_FFFF, 9, 0, 0, 0);
      cyc(0, 0, 0, 9, 0, 0, 0);
      cyc(0, 0, 0, 9, 0, 0, 0);
      cyc(1, 3, 32'h1234_5678, 3, 0, 0, 0);
      cyc(0, 0, 0, 3, 0, 0, 0);

      // randomized traffic
      ir_lvl = 0;
      for (int i = 0; i < 3000; i++) begin
         s.rst = ($urandom % 300 == 0);
         s.op  = 2'($urandom % 4);
         case ($urandom % 8)
            0: s.aw = 9;  1: s.aw = 11; 2: s.aw = 12;
            3: s.aw = 13; 4: s.aw = 14; 5: s.aw = 15;
            default: s.aw = 5'($urandom % 32);
         endcase
         s.dw = $urandom;
         if (s.aw == 11) s.dw = m_count + ($urandom % 12);
         if (s.aw == 9 && $urandom % 4 == 0) s.dw = 32'hFFFF_FFFF;
         s.ar  = ($urandom % 8 == 0) ? 5'($urandom % 32) : 5'(9 + $urandom % 7);
         s.ien = ($urandom % 8 != 0);
         if ($urandom % 6 == 0) ir_lvl = ~ir_lvl;
         s.ir  = ir_lvl;
         s.ret = $urandom & 32'hFFFF_FFFC;
         s.vld = ($urandom % 8 != 0);
         s.stl = ($urandom % 5 == 0);
         step(s);
      end
      cyc(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 block for the 5-stage MIPS pipeline.
- Consumes the controller's cp_oper decode of the instruction in ID, plus the rt operand.
- Produces jump_en and jump_addr back to the controller (ID flush) and the PC mux.
- Holds the interrupt/exception state: STATUS, CAUSE, EPC, COUNT, COMPARE and EBASE (handler base); takes external and timer interrupts and executes MTC0/MFC0/ERET.

Parameters:
HANDLER_ADDR, 32'h0000_0040, reset value of EBASE
SYNC_STAGES, 2, synchroniser depth for ir_in (minimum 2)

Ports:
clk  in  1  main clock
rst  in  1  reset, synchronous, active-high
cp_oper  in  2  from controller: 0 = EXE_CP_NONE, 1 = EXE_CP_STORE (MTC0), 2 = EXE_CP0_ERET, 3 = reserved, treated as NONE
addr_w  in  5  MTC0 target register (inst[15:11])
data_w  in  32  MTC0 data (forwarded rt value)
addr_r  in  5  MFC0 source register
data_r  out  32  MFC0 read data, combinational
ir_en  in  1  global interrupt gate from the top level
ir_in  in  1  external interrupt level, asynchronous
ret_addr  in  32  PC of the instruction currently in ID
id_valid  in  1  ID holds a real instruction
stall  in  1  ID is stalled this cycle (controller reg_stall)
jump_en  out  1  redirect PC and flush ID, combinational
jump_addr  out  32  redirect target

Behaviour:
Register map (all others read 0, writes ignored):
- 9 COUNT: reset 0.
- 11 COMPARE: reset 32'hFFFF_FFFF.
- 12 STATUS: bit0 IE, bit1 EXL, [15:8] IM; other bits read 0; reset 0.
- 13 CAUSE: bit10 IP2 (external), bit15 IP7 (timer), [6:2] ExcCode; reset 0.
- 14 EPC: reset 0.
- 15 EBASE: reset HANDLER_ADDR.

Reset:
- All registers take their reset values at the next edge with rst = 1.
- Synchroniser and edge-detect flops clear to 0.
- jump_en = 0 and jump_addr = 0 while rst = 1.

Commit condition:
- commit = id_valid & ~stall & ~rst.
- No MTC0, ERET or interrupt entry happens without commit; a stalled instruction is re-presented later.

Interrupt sources:
- ir_in passes through SYNC_STAGES flops.
- A rising edge of the synchronised level sets CAUSE.IP2 (sticky).
- IP2 is cleared only by an MTC0 to CAUSE with bit10 = 0.
- COUNT increments by 1 every cycle, wrapping FFFF_FFFF to 0.
- When COUNT == COMPARE, IP7 is set at the next edge.
- Any MTC0 to COMPARE clears IP7; the clear wins over a same-cycle match.
- MTC0 to COUNT loads data_w; that cycle there is no increment.

Interrupt take:
- take = commit & ir_en & IE & ~EXL & |(CAUSE[15:8] & IM) & (cp_oper != ERET).
- On take: jump_en = 1, jump_addr = EBASE.
- At the edge after take: EPC <= ret_addr, EXL <= 1, ExcCode <= 0.
- The ID instruction is flushed, so a same-cycle MTC0 is suppressed and EPC points at it.

ERET:
- Active when commit & cp_oper == ERET.
- jump_en = 1, jump_addr = EPC (the pre-edge value).
- EXL <= 0 at the edge.
- ERET has priority over take; the pending interrupt is taken on the next qualifying cycle.

MTC0:
- Active when commit & cp_oper == STORE & ~take.
- Writes only the writable fields: STATUS {IM, EXL, IE}, CAUSE bit10, EPC, COUNT, COMPARE, EBASE.

MFC0:
- data_r = current register value, with no write bypass.
- A same-cycle MTC0 to the same address returns the old value.

State machine:
- States: NORMAL (EXL = 0) and HANDLER (EXL = 1).
- NORMAL -> HANDLER on take, or on MTC0 STATUS setting EXL.
- HANDLER -> NORMAL on ERET, or on MTC0 clearing EXL.
- No nesting: take is never asserted in HANDLER.

Misc:
- jump_en is high for exactly the cycles in which take or ERET commits; otherwise jump_addr = 0.
- Reset asserted mid-handler returns the block to NORMAL with all registers at reset values.

Test Plan:
- Reset, then MTC0 STATUS = 32'h0000_0401, then pulse ir_in for 3 cycles with ret_addr = 32'h0000_0120 -> take within SYNC_STAGES+2 cycles, jump_en for one cycle, jump_addr = 32'h0000_0040, EPC = 32'h120, STATUS = 32'h403, CAUSE bit10 = 1.
- Same setup but stall = 1 held while pending -> jump_en stays 0; when stall drops, take occurs with that cycle's ret_addr.
- In HANDLER: MTC0 CAUSE = 0, then ERET -> jump_en = 1, jump_addr = 32'h120, EXL = 0, IP2 = 0; no re-take.
- MTC0 COMPARE = 10, MTC0 COUNT = 5, STATUS = 32'h8001 -> IP7 sets when COUNT == 10 and take fires; MTC0 COMPARE = 100 clears IP7.
- ERET and a pending enabled interrupt in the same cycle (EXL = 1, IE = 1) -> ERET redirect to EPC first; take with EBASE on the next committed cycle.
- MTC0 COUNT = 32'hFFFF_FFFF -> next cycle COUNT = 0; MFC0 addr_r = 9 tracks this; addr_r = 3 reads 0.
